// File: rtl/prbs_pkg.sv
// Shared constants, state encoding and the xorshift32 step used by the PRBS stream source.
package prbs_pkg;

    localparam logic [31:0] XS_SEED_DEFAULT = 32'h1;
    localparam int XS_SH_A = 13;
    localparam int XS_SH_B = 17;
    localparam int XS_SH_C = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << XS_SH_A);
        t = t ^ (t >> XS_SH_B);
        t = t ^ (t << XS_SH_C);
        return t;
    endfunction

endpackage

// File: rtl/xorshift32_chain.sv
// Combinational chain of N xorshift32 steps: one beat's worth of words plus the state after the last one.
module xorshift32_chain
    import prbs_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [31:0]     i_state,
    output logic [32*N-1:0] o_words,
    output logic [31:0]     o_state
);

    logic [31:0] w_chain [0:N];

    assign w_chain[0] = i_state;

    for (genvar g = 0; g < N; g++) begin : g_step
        assign w_chain[g+1]      = xs_step(w_chain[g]);
        assign o_words[32*g +: 32] = w_chain[g+1];
    end

    assign o_state = w_chain[N];

endmodule

// File: rtl/axis_prbs_source.sv
// AXI4-Stream source emitting a seeded xorshift32 byte vector of programmable length.
module axis_prbs_source
    import prbs_pkg::*;
#(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    len_bytes,
    input  logic [31:0]         seed,
    output logic                busy,
    output logic                done,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [1:0]          o_dbg_state
);

    localparam int BYTES = DATA_W / 8;
    localparam int WORDS = DATA_W / 32;
    localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

    state_t            r_state;
    logic [31:0]       r_x;
    logic [LEN_W-1:0]  r_rem;
    logic              r_busy;
    logic              r_done;
    logic              r_tvalid;
    logic              r_tlast;
    logic [DATA_W-1:0] r_tdata;
    logic [BYTES-1:0]  r_tkeep;

    logic [31:0]       w_seed_eff;
    logic [31:0]       w_chain_in;
    logic [31:0]       w_chain_state;
    logic [DATA_W-1:0] w_chain_words;
    logic [DATA_W-1:0] w_data_load;
    logic [LEN_W-1:0]  w_rem_load;
    logic [BYTES-1:0]  w_keep_load;
    logic              w_hs;

    // r_rem counts bytes still owed including the beat in the output register.
    function automatic logic [BYTES-1:0] keep_for(input logic [LEN_W-1:0] rem);
        for (int i = 0; i < BYTES; i++)
            keep_for[i] = (LEN_W'(i) < rem);
    endfunction

    assign w_seed_eff  = (seed == 32'h0) ? XS_SEED_DEFAULT : seed;
    assign w_chain_in  = (r_state == IDLE) ? w_seed_eff : r_x;
    assign w_rem_load  = (r_state == IDLE) ? len_bytes : (r_rem - BYTES_L);
    assign w_keep_load = keep_for(w_rem_load);

    // A beat transfers on a rising edge with tvalid & tready; the beat is held until then.
    assign w_hs = r_tvalid & m_axis_tready;

    xorshift32_chain #(.N(WORDS)) u_chain (
        .i_state (w_chain_in),
        .o_words (w_chain_words),
        .o_state (w_chain_state)
    );

    always_comb begin
        w_data_load = '0;
        for (int b = 0; b < BYTES; b++)
            if (w_keep_load[b]) w_data_load[8*b +: 8] = w_chain_words[8*b +: 8];
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state  <= IDLE;
            r_x      <= XS_SEED_DEFAULT;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (len_bytes != '0) begin
                            r_x      <= w_chain_state;
                            r_rem    <= w_rem_load;
                            r_tdata  <= w_data_load;
                            r_tkeep  <= w_keep_load;
                            r_tlast  <= (w_rem_load <= BYTES_L);
                            r_tvalid <= 1'b1;
                            r_state  <= RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        if (r_tlast) begin
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_tdata  <= '0;
                            r_tkeep  <= '0;
                            r_done   <= 1'b1;
                            r_state  <= FIN;
                        end else begin
                            r_x     <= w_chain_state;
                            r_rem   <= w_rem_load;
                            r_tdata <= w_data_load;
                            r_tkeep <= w_keep_load;
                            r_tlast <= (w_rem_load <= BYTES_L);
                        end
                    end
                end
                FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_axis_prbs_source.sv
// Bench for axis_prbs_source: reference xorshift32 model feeds an expected-beat queue drained on handshakes.
module tb_axis_prbs_source;

    localparam int DATA_W = 512;
    localparam int LEN_W  = 32;
    localparam int BYTES  = DATA_W / 8;
    localparam int WORDS  = DATA_W / 32;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              start;
    logic [LEN_W-1:0]  len_bytes;
    logic [31:0]       seed;
    logic              busy;
    logic              done;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DATA_W-1:0] m_axis_tdata;
    logic [BYTES-1:0]  m_axis_tkeep;
    logic              m_axis_tlast;
    logic [1:0]        o_dbg_state;

    logic [DATA_W-1:0] exp_q[$];
    logic [BYTES-1:0]  exp_keep_q[$];
    logic              exp_last_q[$];

    int errors = 0;
    int checks = 0;

    axis_prbs_source #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .start         (start),
        .len_bytes     (len_bytes),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .o_dbg_state   (o_dbg_state)
    );

    // clock / reset
    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        logic [31:0] t;
        t = x ^ (x << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    function automatic logic [31:0] ref_step_n(input logic [31:0] s, input int n);
        logic [31:0] x;
        x = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < n; i++) x = ref_step(x);
        return x;
    endfunction

    task automatic model_push(input logic [31:0] s, input int ln);
        logic [31:0]       x;
        logic [DATA_W-1:0] d;
        logic [BYTES-1:0]  k;
        int                nb;
        x  = (s == 32'h0) ? 32'h1 : s;
        nb = (ln + BYTES - 1) / BYTES;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < WORDS; j++) begin
                x = ref_step(x);
                d[32*j +: 32] = x;
            end
            for (int i = 0; i < BYTES; i++) begin
                if (b * BYTES + i < ln) begin
                    k[i] = 1'b1;
                end else begin
                    k[i] = 1'b0;
                    d[8*i +: 8] = 8'h00;
                end
            end
            exp_q.push_back(d);
            exp_keep_q.push_back(k);
            exp_last_q.push_back(b == nb - 1);
        end
    endtask

    // driver: issue one vector, drain it through the scoreboard, check the done/busy tail
    task automatic run_vector(input logic [31:0] s, input int ln, input bit rnd,
                              output logic [DATA_W-1:0] first_data,
                              output logic [BYTES-1:0] first_keep,
                              output logic [DATA_W-1:0] last_data,
                              output logic [BYTES-1:0] last_keep,
                              output int beats);
        int                budget;
        bit                stalled;
        logic [DATA_W-1:0] hold_d;
        logic [BYTES-1:0]  hold_k;
        logic              hold_l;
        logic [DATA_W-1:0] ed;
        logic [BYTES-1:0]  ek;
        logic              el;
        first_data = '0; first_keep = '0; last_data = '0; last_keep = '0;
        hold_d = '0; hold_k = '0; hold_l = 1'b0;
        beats = 0; budget = 0; stalled = 1'b0;

        @(negedge ap_clk);
        start = 1'b1; len_bytes = LEN_W'(ln); seed = s; m_axis_tready = 1'b0;
        model_push(s, ln);
        @(negedge ap_clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        checks++;
        if (o_dbg_state !== ((ln > 0) ? 2'd1 : 2'd2)) begin
            errors++; $display("FAIL state_after_start: got %0d expected %0d", o_dbg_state, (ln > 0) ? 1 : 2);
        end

        while (exp_q.size() > 0 && budget < 1000) begin
            if (stalled) begin
                checks++;
                if (m_axis_tdata !== hold_d || m_axis_tkeep !== hold_k || m_axis_tlast !== hold_l) begin
                    errors++; $display("FAIL stall_stable: got keep %h last %b expected keep %h last %b", m_axis_tkeep, m_axis_tlast, hold_k, hold_l);
                end
            end
            checks++;
            if (m_axis_tvalid !== 1'b1) begin
                errors++; $display("FAIL tvalid_held: got %b expected 1 (beat %0d)", m_axis_tvalid, beats);
            end
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            len_bytes = LEN_W'($urandom_range(0, 500));
            seed = $urandom;
            if (m_axis_tvalid && m_axis_tready) begin
                ed = exp_q.pop_front();
                ek = exp_keep_q.pop_front();
                el = exp_last_q.pop_front();
                checks++;
                if (m_axis_tdata !== ed) begin
                    errors++; $display("FAIL beat%0d_data: got %h expected %h", beats, m_axis_tdata, ed);
                end
                checks++;
                if (m_axis_tkeep !== ek) begin
                    errors++; $display("FAIL beat%0d_keep: got %h expected %h", beats, m_axis_tkeep, ek);
                end
                checks++;
                if (m_axis_tlast !== el) begin
                    errors++; $display("FAIL beat%0d_last: got %b expected %b", beats, m_axis_tlast, el);
                end
                if (beats == 0) begin
                    first_data = m_axis_tdata; first_keep = m_axis_tkeep;
                end
                last_data = m_axis_tdata; last_keep = m_axis_tkeep;
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = m_axis_tvalid;
                hold_d = m_axis_tdata; hold_k = m_axis_tkeep; hold_l = m_axis_tlast;
            end
            @(negedge ap_clk);
            budget++;
        end
        start = 1'b0;
        m_axis_tready = 1'b0;
        checks++;
        if (budget >= 1000) begin
            errors++; $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
            exp_q.delete(); exp_keep_q.delete(); exp_last_q.delete();
        end

        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL done_pulse: got done %b busy %b tvalid %b expected 1 1 0", done, busy, m_axis_tvalid);
        end
        @(negedge ap_clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL after_done: got done %b busy %b tvalid %b expected 0 0 0", done, busy, m_axis_tvalid);
        end
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done: got %b %b expected 0 0", busy, done);
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_valid_last: got %b %b expected 0 0", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
            errors++; $display("FAIL reset_data_keep: got keep %h expected 0", m_axis_tkeep);
        end
        checks++;
        if (o_dbg_state !== 2'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state);
        end
        ap_rst_n = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        run_vector(32'h1, 8, 1'b0, fd, fk, ld, lk, nb);
        checks++;
        if (fd[31:0] !== 32'h00042021) begin
            errors++; $display("FAIL single_word0: got %h expected 00042021", fd[31:0]);
        end
        checks++;
        if (fd[63:32] !== 32'h04080601) begin
            errors++; $display("FAIL single_word1: got %h expected 04080601", fd[63:32]);
        end
        checks++;
        if (fk !== 64'hFF || nb != 1) begin
            errors++; $display("FAIL single_keep_beats: got %h/%0d expected ff/1", fk, nb);
        end
    endtask

    task automatic test_seed_zero();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        run_vector(32'h0, 4, 1'b0, fd, fk, ld, lk, nb);
        checks++;
        if (fd[31:0] !== 32'h00042021 || fk !== 64'hF) begin
            errors++; $display("FAIL seed_zero: got %h keep %h expected 00042021 keep f", fd[31:0], fk);
        end
    endtask

    task automatic test_two_beats();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        run_vector(32'h1, 128, 1'b0, fd, fk, ld, lk, nb);
        checks++;
        if (nb != 2 || fk !== {BYTES{1'b1}} || lk !== {BYTES{1'b1}}) begin
            errors++; $display("FAIL two_beats: got %0d beats keep %h/%h expected 2 full", nb, fk, lk);
        end
        checks++;
        if (ld[31:0] !== ref_step_n(32'h1, 17)) begin
            errors++; $display("FAIL beat1_step17: got %h expected %h", ld[31:0], ref_step_n(32'h1, 17));
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        run_vector(32'hDEADBEEF, 130, 1'b1, fd, fk, ld, lk, nb);
        checks++;
        if (nb != 3 || lk !== 64'h3) begin
            errors++; $display("FAIL stall_len130: got %0d beats last keep %h expected 3 / 3", nb, lk);
        end
    endtask

    task automatic test_len_zero();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        run_vector(32'h5, 0, 1'b0, fd, fk, ld, lk, nb);
        checks++;
        if (nb != 0) begin
            errors++; $display("FAIL len_zero_beats: got %0d expected 0", nb);
        end
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        @(negedge ap_clk);
        start = 1'b1; len_bytes = 32'd256; seed = 32'h1;
        @(negedge ap_clk);
        start = 1'b0; m_axis_tready = 1'b1;
        @(negedge ap_clk);
        m_axis_tready = 1'b0; ap_rst_n = 1'b0;
        @(negedge ap_clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got tvalid %b busy %b tlast %b expected 0 0 0", m_axis_tvalid, busy, m_axis_tlast);
        end
        ap_rst_n = 1'b1;
        run_vector(32'h1, 8, 1'b0, fd, fk, ld, lk, nb);
        checks++;
        if (fd[31:0] !== 32'h00042021) begin
            errors++; $display("FAIL restart_word0: got %h expected 00042021", fd[31:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] fd, ld;
        logic [BYTES-1:0]  fk, lk;
        int                nb;
        int                ln;
        for (int v = 0; v < 6; v++) begin
            ln = $urandom_range(1, 300);
            run_vector($urandom, ln, 1'b1, fd, fk, ld, lk, nb);
            checks++;
            if (nb != (ln + BYTES - 1) / BYTES) begin
                errors++; $display("FAIL b2b_beats: got %0d expected %0d (len %0d)", nb, (ln + BYTES - 1) / BYTES, ln);
            end
        end
    endtask

    initial begin
        start = 1'b0; len_bytes = '0; seed = '0; m_axis_tready = 1'b0; ap_rst_n = 1'b0;
        test_reset();
        test_single_beat();
        test_seed_zero();
        test_two_beats();
        test_stall();
        test_len_zero();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_prbs_source.md
# axis_prbs_source

Synthesizable AXI4-Stream source that emits a pseudo-random byte vector of programmable length from a xorshift32 generator. It is the transmit-side counterpart of the bench byte comparator. It lets on-chip datapaths and loopback kernels consume reproducible random vectors without host traffic. It sits in front of the kernel datapath under test, and a bench or checker regenerates the same sequence from the same seed.

## Interface
- DATA_W, 512: stream data width in bits; multiple of 32.
- LEN_W, 32: width of the byte-length field.
- BYTES (localparam), DATA_W/8: bytes per beat.
- WORDS (localparam), DATA_W/32: 32-bit words per beat.
- ap_clk  in  1  sole clock; everything on the rising edge.
- ap_rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request a vector; sampled only when busy=0.
- len_bytes  in  LEN_W  vector length in bytes; latched with start.
- seed  in  32  generator seed; latched with start; 0 is replaced by 32'h1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of each vector.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tdata  out  DATA_W  beat payload.
- m_axis_tkeep  out  BYTES  byte enables.
- m_axis_tlast  out  1  final beat of the vector.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1, len_bytes>0: latch len and seed, compute beat 0 into the output register, then RUN.
- IDLE, start=1, len_bytes=0: go to FIN; no beats are emitted.
- RUN: a handshake (tvalid & tready) on a non-last beat loads the next beat in the same edge. A handshake on the last beat goes to FIN with tvalid=0.
- FIN: done=1 for exactly one cycle, then IDLE.
- start while busy is ignored; no queueing.
- Generator step: x ^= x<<13; x ^= x>>17; x ^= x<<5, 32-bit wrap.
- Word j (0-based, little-endian lane) of beat k carries x after 16-equivalent step count WORDS*k+j+1 from the seed. The first word is therefore one step past the seed. The state register holds the last word emitted.
- Beat count = ceil(len/BYTES); the internal remaining-byte counter is LEN_W bits.
- Last beat: bytes at index ≥ (len mod BYTES) are zeroed with tkeep=0, unless len mod BYTES = 0, which gives a full tkeep.
- All non-last beats have tkeep all-ones and tlast=0.
- Stream byte n equals byte n of the little-endian concatenation of the generator words.

## Timing
- Reset (ap_rst_n=0 at an edge): state IDLE; busy, done, tvalid, tlast = 0; tdata, tkeep = 0; generator state 32'h1.
- Reset mid-vector abandons the vector without tlast. This is allowed; sinks must be reset together.
- Latency: start accepted at edge t gives tvalid=1 and busy=1 after edge t. With len=0, done=1 after edge t, busy=1 for that one cycle.
- Throughput: one beat per cycle while tready=1.
- While tvalid=1 and tready=0, tdata, tkeep and tlast are held stable. tvalid never drops before its handshake, except on reset.
- done rises the cycle after the last handshake; busy falls together with done. The next start is accepted in the cycle after done.

## Structure
- Shared package, prbs_pkg: XS_SEED_DEFAULT = 32'h1, the step shift constants 13/17/5, and a state_t enum {IDLE, RUN, FIN}.
- Sub-module xorshift32_chain: combinational, parameter N=WORDS. Inputs are the state word; outputs are N successive words plus the final state.
- The top level holds the FSM, the length counter, the output register and the tkeep mask.

## Test plan
- seed=1, len=8, DATA_W=512 -> one beat: word0=32'h00042021, word1=32'h04080601, tkeep=64'hFF, tlast=1, then a done pulse one cycle later.
- seed=0, len=4 -> identical word0 to seed=1 (32'h00042021), tkeep=64'hF.
- seed=1, len=128, tready=1 -> 2 beats, both tkeep all-ones, tlast on beat 1 only. Beat 1 word0 equals step 17 of the reference model.
- len=130, tready toggling randomly -> 3 beats, final tkeep=64'h3, data stable across every stall, byte stream matches the model.
- len=0 -> no tvalid, done one cycle after start, busy high for exactly 1 cycle.
- Reset asserted mid-vector, then start with seed=1, len=8 -> tvalid drops at the reset edge, and the new vector restarts at word0=32'h00042021.
